// File: rtl/seg7_paged_display.sv
// seg7_paged_display: pages a held hex value across a multiplexed common-anode 7-segment array.
module seg7_paged_display #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int PAGE_DIV = 100000000,
  localparam int NUM_PAGES = (VALUE_W + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS),
  localparam int PW = NUM_PAGES > 1 ? $clog2(NUM_PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  auto_page,
  input  logic                  page_next,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [PW-1:0]         page_idx
);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int QW = PAGE_DIV > 1 ? $clog2(PAGE_DIV) : 1;
  localparam int NW = $clog2(NUM_PAGES * NUM_DIGITS) + 1;
  localparam int PADW = NUM_PAGES * NUM_DIGITS * 4;
  localparam logic [6:0] SEG_LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [VALUE_W-1:0] held;
  logic [SW-1:0] scan;
  logic [RW-1:0] rcnt;
  logic [QW-1:0] pcnt;
  logic [NW-1:0] nib_idx;
  logic [PADW-1:0] upper;
  logic [PW-1:0] page_inc;
  logic [6:0] code;
  logic lz, dp_on, r_tc, p_tc;
  // upper holds the current nibble and everything above it, so a zero test covers leading-zero blanking
  always_comb begin
    nib_idx = NW'(page_idx) * NW'(NUM_DIGITS) + NW'(scan);
    upper = PADW'(held) >> {nib_idx, 2'b00};
    lz = blank_lz && nib_idx != '0 && upper == '0;
    code = lz ? 7'h7F : SEG_LUT[upper[3:0]];
    dp_on = NUM_PAGES > 1 && (NW'(page_idx) >= NW'(NUM_DIGITS) || NW'(page_idx) == NW'(scan));
    r_tc = rcnt == RW'(REFRESH_DIV - 1);
    p_tc = pcnt == QW'(PAGE_DIV - 1);
    page_inc = page_idx == PW'(NUM_PAGES - 1) ? '0 : page_idx + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      held <= '0;
      page_idx <= '0;
      scan <= '0;
      rcnt <= '0;
      pcnt <= '0;
      an <= '1;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      rcnt <= r_tc ? '0 : rcnt + 1'b1;
      if (r_tc) scan <= scan == SW'(NUM_DIGITS - 1) ? '0 : scan + 1'b1;
      if (load) begin
        held <= value;
        page_idx <= '0;
        pcnt <= '0;
      end else if (auto_page) begin
        pcnt <= p_tc ? '0 : pcnt + 1'b1;
        if (p_tc) page_idx <= page_inc;
      end else begin
        pcnt <= '0;
        if (page_next) page_idx <= page_inc;
      end
      an <= enable ? ~(NUM_DIGITS'(1) << scan) : '1;
      seg <= enable ? code : 7'h7F;
      dp <= ~(enable && dp_on);
    end
  end
endmodule
